memory_map_master_n: RTL and testbench
======================================

# memory_map_master_n

Parametrised, registered successor to the core's memory-map master. It decodes a core load/store address against N_SLAVES address windows and drives one slave's read or write select with a word-offset address. It waits on a per-slave ready handshake, with a timeout, and returns read data with a bus-error flag. It sits between the multicycle core's memory port and the ROM/UART/peripheral slaves, and stalls the core while an access is in flight.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address bus width
- N_SLAVES, 4, number of slave windows (1..8)
- BASES, {32'h1001_0060, 32'h1001_0040, 32'h1001_0020, 32'h0040_0000}, packed N_SLAVES×ADDR_WIDTH window bases; slot 0 is LSBs
- LIMITS, {32'h1001_0080, 32'h1001_0060, 32'h1001_0040, 32'h1001_0020}, packed exclusive upper bounds
- TIMEOUT, 15, maximum ACCESS cycles without ready before an error is returned
- clk  in  1  clock; all logic rises on posedge
- rst  in  1  reset; synchronous and active-high
- address  in  ADDR_WIDTH  core byte address
- wd  in  DATA_WIDTH  core write data
- we  in  1  core write request, held until stall is low
- re  in  1  core read request, held until stall is low
- rd  out  DATA_WIDTH  registered read data
- stall  out  1  core must hold the request
- bus_err  out  1  unmapped access or timeout, valid in RESP
- map_Address  out  ADDR_WIDTH  (address − base) >> 2, registered
- map_Data  out  DATA_WIDTH  latched wd
- HSel  out  N_SLAVES  one-hot access select
- WSel  out  N_SLAVES  one-hot write enable (subset of HSel)
- HRData  in  N_SLAVES×DATA_WIDTH  packed slave read data
- HReady  in  N_SLAVES  slave completion

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE, with we|re: decode the address.
  - Hit on slave k: latch k, map_Address, map_Data and we, then go to ACCESS.
  - Miss: go to RESP with bus_err=1 and rd=0.
- we and re asserted together is treated as a write.
- Overlapping windows: the lowest index wins.
- A hit requires BASES[k] ≤ address < LIMITS[k], compared unsigned.
- ACCESS:
  - HSel[k]=1; WSel[k]=latched we.
  - On HReady[k]=1, go to RESP. For a read, capture rd ← HRData[k]; for a write, rd=0. bus_err=0.
  - The timeout counter increments each ACCESS cycle. When it reaches TIMEOUT with no ready, go to RESP with bus_err=1, rd=0.
  - HReady from any non-selected slave is ignored.
- RESP: lasts one cycle. HSel and WSel are low, then the FSM returns to IDLE. A request still held in IDLE is a new access.
- stall = (we|re) & (state≠RESP).
- rd and bus_err hold their values until the next RESP.
- The subtraction for map_Address is ADDR_WIDTH-wide and modulo; the low 2 address bits are dropped.
- Reset values: state=IDLE, rd=0, bus_err=0, map_Address=0, map_Data=0, HSel=0, WSel=0, counter=0.
- Reset mid-ACCESS: selects drop in the next cycle and the access is abandoned with no response.

## Timing
- Request seen in IDLE at cycle T0.
  - Mapped access: selects asserted in T1.
  - Slave ready in T1 + n: RESP in T2 + n, where rd/bus_err are valid and stall is low.
- Fastest mapped access: 3 cycles (slave ready in the same cycle as the select).
- Unmapped access: 2 cycles (IDLE → RESP).
- Timeout: RESP occurs TIMEOUT+1 cycles after the first ACCESS cycle.
- Selects are registered and glitch-free; HSel is never active outside ACCESS.

## Structure
- Package memory_map_pkg holds:
  - the state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - default base/limit constants;
  - a clog2 width constant for the slave index.
- Sub-module addr_region_decoder (combinational): takes address, BASES and LIMITS and outputs hit plus a priority-encoded index. The top level contains the FSM, the latches, the timeout counter and the rd mux.

## Test plan
- Read ROM at 0x0040_0010, with HReady[0]=1 and HRData[0]=0xDEADBEEF:
  - HSel=4'b0001 and map_Address=0x4 in T1;
  - rd=0xDEADBEEF, bus_err=0 and stall=0 in T2.
- Write UART at 0x1001_0024 with wd=0x41, and HReady[1] delayed 3 cycles:
  - WSel=4'b0010 held 4 cycles, map_Address=0x1, map_Data=0x41;
  - stall high until RESP.
- Read 0x0000_0100 (unmapped): RESP at T1 with bus_err=1, rd=0, and no HSel ever asserted.
- Read slave 2 at 0x1001_0040 with HReady never asserted: bus_err=1 in RESP exactly 16 cycles after the first ACCESS cycle (TIMEOUT=15).
- rst=1 in the 2nd ACCESS cycle of a slave-3 read: all outputs 0 on the next edge; a fresh read afterwards completes normally.
- Back-to-back: a read to slave 0 followed immediately by a write to slave 1 with we=re=1: the second access is treated as a write, and the HSel pattern is 0001, 0000, 0010 across ACCESS, RESP, ACCESS.

Source files
------------

// File: rtl/memory_map_pkg.sv
// Shared definitions for the memory-map master: FSM encoding, default
// slave windows and the slave-index width helper.
package memory_map_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
    localparam int unsigned DEFAULT_N_SLAVES   = 4;

    // Slot 0 (ROM) sits in the LSBs, followed by UART and two peripherals.
    localparam logic [DEFAULT_N_SLAVES*DEFAULT_ADDR_WIDTH-1:0] DEFAULT_BASES =
        {32'h1001_0060, 32'h1001_0040, 32'h1001_0020, 32'h0040_0000};
    localparam logic [DEFAULT_N_SLAVES*DEFAULT_ADDR_WIDTH-1:0] DEFAULT_LIMITS =
        {32'h1001_0080, 32'h1001_0060, 32'h1001_0040, 32'h1001_0020};

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEFAULT_IDX_W = idx_width(DEFAULT_N_SLAVES);

endpackage

// File: rtl/addr_region_decoder.sv
// Combinational window decoder: reports whether the address falls inside any
// [base, limit) window and the lowest-numbered matching slave.
module addr_region_decoder
    import memory_map_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned N_SLAVES   = 4,
    parameter int unsigned IDX_W      = DEFAULT_IDX_W
) (
    input  logic [ADDR_WIDTH-1:0]          address,
    input  logic [N_SLAVES*ADDR_WIDTH-1:0] bases,
    input  logic [N_SLAVES*ADDR_WIDTH-1:0] limits,
    output logic                           hit,
    output logic [IDX_W-1:0]               idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        // First match is kept, so overlapping windows resolve to the lowest index.
        for (int unsigned k = 0; k < N_SLAVES; k++) begin
            if (!hit &&
                (address >= bases[k*ADDR_WIDTH +: ADDR_WIDTH]) &&
                (address <  limits[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit = 1'b1;
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/memory_map_master_n.sv
// Registered memory-map master: decodes a core access to one of N_SLAVES
// windows, waits on the slave's ready with a timeout and returns data/error.
module memory_map_master_n
    import memory_map_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned N_SLAVES   = 4,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] BASES  = DEFAULT_BASES,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] LIMITS = DEFAULT_LIMITS,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          address,
    input  logic [DATA_WIDTH-1:0]          wd,
    input  logic                           we,
    input  logic                           re,
    output logic [DATA_WIDTH-1:0]          rd,
    output logic                           stall,
    output logic                           bus_err,
    output logic [ADDR_WIDTH-1:0]          map_Address,
    output logic [DATA_WIDTH-1:0]          map_Data,
    output logic [N_SLAVES-1:0]            HSel,
    output logic [N_SLAVES-1:0]            WSel,
    input  logic [N_SLAVES*DATA_WIDTH-1:0] HRData,
    input  logic [N_SLAVES-1:0]            HReady
);

    localparam int unsigned IDX_W = idx_width(N_SLAVES);
    localparam int unsigned CNT_W = idx_width(TIMEOUT + 1);

    state_t state, state_next;

    logic                  req;
    logic                  dec_hit;
    logic [IDX_W-1:0]      dec_idx;
    logic [ADDR_WIDTH-1:0] dec_base;
    logic [ADDR_WIDTH-1:0] dec_offset;
    logic [N_SLAVES-1:0]   dec_onehot;

    logic [IDX_W-1:0]      sel_q;
    logic                  we_q;
    logic [CNT_W-1:0]      cnt;
    logic                  sel_ready;
    logic                  timed_out;

    addr_region_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .N_SLAVES   (N_SLAVES),
        .IDX_W      (IDX_W)
    ) u_decoder (
        .address (address),
        .bases   (BASES),
        .limits  (LIMITS),
        .hit     (dec_hit),
        .idx     (dec_idx)
    );

    assign req        = we | re;
    assign dec_base   = BASES[dec_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign dec_offset = address - dec_base;
    assign dec_onehot = N_SLAVES'(1) << dec_idx;
    assign sel_ready  = HReady[sel_q];
    assign timed_out  = (cnt == CNT_W'(TIMEOUT));
    assign stall      = req & (state != RESP);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = dec_hit ? ACCESS : RESP;
            ACCESS:  if (sel_ready || timed_out) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Selects are loaded on the IDLE->ACCESS edge and cleared on leaving
    // ACCESS, so they come straight from flops and never outside ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd          <= '0;
            bus_err     <= 1'b0;
            map_Address <= '0;
            map_Data    <= '0;
            HSel        <= '0;
            WSel        <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req) begin
                        if (dec_hit) begin
                            sel_q       <= dec_idx;
                            we_q        <= we;
                            map_Address <= dec_offset >> 2;
                            map_Data    <= wd;
                            HSel        <= dec_onehot;
                            WSel        <= we ? dec_onehot : '0;
                        end else begin
                            rd      <= '0;
                            bus_err <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        HSel    <= '0;
                        WSel    <= '0;
                        rd      <= we_q ? '0 : HRData[sel_q*DATA_WIDTH +: DATA_WIDTH];
                        bus_err <= 1'b0;
                    end else if (timed_out) begin
                        HSel    <= '0;
                        WSel    <= '0;
                        rd      <= '0;
                        bus_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_map_master_n.sv
// Directed self-checking bench for memory_map_master_n with default windows.
module tb_memory_map_master_n;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  address;
    logic [31:0]  wd;
    logic         we;
    logic         re;
    logic [31:0]  rd;
    logic         stall;
    logic         bus_err;
    logic [31:0]  map_Address;
    logic [31:0]  map_Data;
    logic [3:0]   HSel;
    logic [3:0]   WSel;
    logic [127:0] HRData;
    logic [3:0]   HReady;

    int tests_run = 0;
    int tests_failed = 0;

    memory_map_master_n #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .N_SLAVES   (4),
        .TIMEOUT    (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .wd          (wd),
        .we          (we),
        .re          (re),
        .rd          (rd),
        .stall       (stall),
        .bus_err     (bus_err),
        .map_Address (map_Address),
        .map_Data    (map_Data),
        .HSel        (HSel),
        .WSel        (WSel),
        .HRData      (HRData),
        .HReady      (HReady)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are checked on the falling edge.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; address = '0; wd = '0; we = 1'b0; re = 1'b0;
        HRData = '0; HReady = '0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        tests_run++;
        if ({rd, bus_err, map_Address, map_Data, HSel, WSel, stall} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: rd=%h err=%b maddr=%h mdata=%h hsel=%b wsel=%b stall=%b, all required 0",
                     rd, bus_err, map_Address, map_Data, HSel, WSel, stall);
        end
    endtask

    task automatic test_unmapped();
        address = 32'h0000_0100; re = 1'b1; HReady = 4'b1111;
        #1;
        tests_run++;
        if (stall !== 1'b1 || HSel !== 4'b0000) begin
            tests_failed++; $display("FAIL unmapped_idle: stall=%b hsel=%b required 1/0000", stall, HSel);
        end
        cyc();
        tests_run++;
        if (bus_err !== 1'b1 || rd !== 32'h0) begin
            tests_failed++; $display("FAIL unmapped_resp: err=%b rd=%h required 1/00000000", bus_err, rd);
        end
        tests_run++;
        if (stall !== 1'b0 || HSel !== 4'b0000 || WSel !== 4'b0000) begin
            tests_failed++; $display("FAIL unmapped_sel: stall=%b hsel=%b wsel=%b required 0/0000/0000", stall, HSel, WSel);
        end
        re = 1'b0;
        cyc();
        tests_run++;
        if (HSel !== 4'b0000 || bus_err !== 1'b1) begin
            tests_failed++; $display("FAIL unmapped_hold: hsel=%b err=%b required 0000/1", HSel, bus_err);
        end
    endtask

    task automatic test_rom_read();
        address = 32'h0040_0010; re = 1'b1; HReady = 4'b0001;
        HRData = '0; HRData[31:0] = 32'hDEAD_BEEF;
        cyc();
        tests_run++;
        if (HSel !== 4'b0001 || WSel !== 4'b0000 || map_Address !== 32'h4) begin
            tests_failed++; $display("FAIL rom_access: hsel=%b wsel=%b maddr=%h required 0001/0000/00000004", HSel, WSel, map_Address);
        end
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++; $display("FAIL rom_stall: stall=%b required 1", stall);
        end
        cyc();
        tests_run++;
        if (rd !== 32'hDEAD_BEEF || bus_err !== 1'b0 || stall !== 1'b0 || HSel !== 4'b0000) begin
            tests_failed++; $display("FAIL rom_resp: rd=%h err=%b stall=%b hsel=%b required deadbeef/0/0/0000", rd, bus_err, stall, HSel);
        end
        re = 1'b0; HReady = '0;
        cyc();
    endtask

    task automatic test_uart_write();
        address = 32'h1001_0024; wd = 32'h41; we = 1'b1; HReady = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            cyc();
            tests_run++;
            if (WSel !== 4'b0010 || HSel !== 4'b0010 || stall !== 1'b1) begin
                tests_failed++; $display("FAIL uart_access%0d: wsel=%b hsel=%b stall=%b required 0010/0010/1", i, WSel, HSel, stall);
            end
            if (i == 3) HReady = 4'b0010;
        end
        tests_run++;
        if (map_Address !== 32'h1 || map_Data !== 32'h41) begin
            tests_failed++; $display("FAIL uart_map: maddr=%h mdata=%h required 00000001/00000041", map_Address, map_Data);
        end
        cyc();
        tests_run++;
        if (WSel !== 4'b0000 || HSel !== 4'b0000 || stall !== 1'b0 || bus_err !== 1'b0 || rd !== 32'h0) begin
            tests_failed++; $display("FAIL uart_resp: wsel=%b hsel=%b stall=%b err=%b rd=%h required 0000/0000/0/0/00000000",
                                     WSel, HSel, stall, bus_err, rd);
        end
        we = 1'b0; HReady = '0;
        cyc();
    endtask

    task automatic test_timeout();
        address = 32'h1001_0040; re = 1'b1; HReady = 4'b1011;
        HRData = {4{32'hFFFF_FFFF}};
        for (int i = 0; i < 16; i++) begin
            cyc();
            tests_run++;
            if (HSel !== 4'b0100 || stall !== 1'b1 || bus_err !== 1'b0) begin
                tests_failed++; $display("FAIL timeout_access%0d: hsel=%b stall=%b err=%b required 0100/1/0", i, HSel, stall, bus_err);
            end
        end
        cyc();
        tests_run++;
        if (bus_err !== 1'b1 || rd !== 32'h0 || stall !== 1'b0 || HSel !== 4'b0000) begin
            tests_failed++; $display("FAIL timeout_resp: err=%b rd=%h stall=%b hsel=%b required 1/00000000/0/0000", bus_err, rd, stall, HSel);
        end
        re = 1'b0; HReady = '0;
        cyc();
    endtask

    task automatic test_reset_mid_access();
        address = 32'h1001_0068; wd = 32'h55; re = 1'b1; HReady = 4'b0000;
        cyc();
        tests_run++;
        if (HSel !== 4'b1000 || map_Address !== 32'h2 || map_Data !== 32'h55) begin
            tests_failed++; $display("FAIL rstmid_access: hsel=%b maddr=%h mdata=%h required 1000/00000002/00000055", HSel, map_Address, map_Data);
        end
        cyc();
        rst = 1'b1; re = 1'b0;
        cyc();
        tests_run++;
        if ({rd, bus_err, map_Address, map_Data, HSel, WSel, stall} !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: rd=%h err=%b maddr=%h mdata=%h hsel=%b wsel=%b stall=%b, all required 0",
                     rd, bus_err, map_Address, map_Data, HSel, WSel, stall);
        end
        rst = 1'b0;
        cyc();
        address = 32'h1001_007C; re = 1'b1; HReady = 4'b1000;
        HRData = '0; HRData[127:96] = 32'h1234_5678;
        cyc();
        tests_run++;
        if (HSel !== 4'b1000 || map_Address !== 32'h7) begin
            tests_failed++; $display("FAIL rstmid_fresh_access: hsel=%b maddr=%h required 1000/00000007", HSel, map_Address);
        end
        cyc();
        tests_run++;
        if (rd !== 32'h1234_5678 || bus_err !== 1'b0 || stall !== 1'b0) begin
            tests_failed++; $display("FAIL rstmid_fresh_resp: rd=%h err=%b stall=%b required 12345678/0/0", rd, bus_err, stall);
        end
        re = 1'b0; HReady = '0;
        cyc();
    endtask

    task automatic test_back_to_back();
        address = 32'h0040_0000; re = 1'b1; we = 1'b0; HReady = 4'b0011;
        HRData = '0; HRData[31:0] = 32'hA5A5_0001;
        cyc();
        tests_run++;
        if (HSel !== 4'b0001 || WSel !== 4'b0000) begin
            tests_failed++; $display("FAIL b2b_access1: hsel=%b wsel=%b required 0001/0000", HSel, WSel);
        end
        cyc();
        tests_run++;
        if (HSel !== 4'b0000 || rd !== 32'hA5A5_0001 || stall !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_resp1: hsel=%b rd=%h stall=%b required 0000/a5a50001/0", HSel, rd, stall);
        end
        address = 32'h1001_0028; wd = 32'h99; we = 1'b1; re = 1'b1;
        cyc();
        tests_run++;
        if (HSel !== 4'b0000 || stall !== 1'b1) begin
            tests_failed++; $display("FAIL b2b_idle: hsel=%b stall=%b required 0000/1", HSel, stall);
        end
        cyc();
        tests_run++;
        if (HSel !== 4'b0010 || WSel !== 4'b0010 || map_Address !== 32'h2 || map_Data !== 32'h99) begin
            tests_failed++; $display("FAIL b2b_access2: hsel=%b wsel=%b maddr=%h mdata=%h required 0010/0010/00000002/00000099",
                                     HSel, WSel, map_Address, map_Data);
        end
        cyc();
        tests_run++;
        if (rd !== 32'h0 || bus_err !== 1'b0 || HSel !== 4'b0000 || WSel !== 4'b0000) begin
            tests_failed++; $display("FAIL b2b_resp2: rd=%h err=%b hsel=%b wsel=%b required 00000000/0/0000/0000", rd, bus_err, HSel, WSel);
        end
        we = 1'b0; re = 1'b0; HReady = '0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_unmapped();
        test_rom_read();
        test_uart_write();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
